// File: rtl/wb_master_arbiter_if.sv
// Wishbone bus bundle between the masters, the round-robin arbiter and the shared slave decode.
// The arbiter takes the slave modport; the bench or surrounding fabric takes the master modport.
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 16
);
  logic [NUM_MASTERS-1:0]            i_m_cyc;
  logic [NUM_MASTERS-1:0]            i_m_stb;
  logic [NUM_MASTERS-1:0]            i_m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_adr;
  logic [NUM_MASTERS*8-1:0]          i_m_dat;
  logic [7:0]                        o_m_dat;
  logic [NUM_MASTERS-1:0]            o_m_ack;
  logic [NUM_MASTERS-1:0]            o_m_err;
  logic                              o_s_cyc;
  logic                              o_s_stb;
  logic                              o_s_we;
  logic [ADDR_WIDTH-1:0]             o_s_adr;
  logic [7:0]                        o_s_dat;
  logic [7:0]                        i_s_dat;
  logic                              i_s_ack;
  logic [NUM_MASTERS-1:0]            o_gnt;
  logic [7:0]                        o_timeout_cnt;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_s_dat, i_s_ack,
    output o_m_dat, o_m_ack, o_m_err, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat,
           o_gnt, o_timeout_cnt
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_s_dat, i_s_ack,
    input  o_m_dat, o_m_ack, o_m_err, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat,
           o_gnt, o_timeout_cnt
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter with a per-transfer ack watchdog that errors out
// and blocks the strobe of a master whose slave never answers.
module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                i_clk,
  input logic                i_rst_n,
  wb_master_arbiter_if.slave bus
);
  localparam int          IDX_W    = $clog2(NUM_MASTERS);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]       last_reg, last_next;
  logic [15:0]            wd_cnt_reg, wd_cnt_next;
  logic                   blocked_reg, blocked_next;
  logic [NUM_MASTERS-1:0] err_reg, err_next;
  logic [7:0]             timeout_cnt_reg, timeout_cnt_next;

  logic [IDX_W-1:0]       gidx;
  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic                   g_cyc, g_stb, g_we;
  logic [ADDR_WIDTH-1:0]  g_adr;
  logic [7:0]             g_dat;
  logic                   s_cyc, s_stb, s_we;
  logic [ADDR_WIDTH-1:0]  s_adr;
  logic [7:0]             s_dat;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_reg[i]) gidx = IDX_W'(i);
    end
  end

  assign g_cyc = bus.i_m_cyc[gidx];
  assign g_stb = bus.i_m_stb[gidx];
  assign g_we  = bus.i_m_we[gidx];
  assign g_adr = bus.i_m_adr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_dat = bus.i_m_dat[int'(gidx)*8 +: 8];

  // Scan from the farthest rotation down so the nearest requester after last wins.
  always_comb begin
    pick       = last_reg;
    pick_valid = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (bus.i_m_cyc[(int'(last_reg) + k) % NUM_MASTERS]) begin
        pick       = IDX_W'((int'(last_reg) + k) % NUM_MASTERS);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      last_reg        <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt_reg      <= '0;
      blocked_reg     <= 1'b0;
      err_reg         <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      last_reg        <= last_next;
      wd_cnt_reg      <= wd_cnt_next;
      blocked_reg     <= blocked_next;
      err_reg         <= err_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next       = BUS;
          gnt_next         = '0;
          gnt_next[pick]   = 1'b1;
          last_next        = pick;
        end
      end
      BUS: begin
        if (!g_cyc) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    if (state_reg == BUS) begin
      s_cyc = g_cyc;
      s_stb = g_stb & ~blocked_reg;
      s_we  = g_we;
      s_adr = g_adr;
      s_dat = g_dat;
    end
  end

  // An ack in the limit cycle takes the normal path: the fire branch needs ack low.
  always_comb begin
    wd_cnt_next      = '0;
    blocked_next     = blocked_reg;
    err_next         = '0;
    timeout_cnt_next = timeout_cnt_reg;
    if (state_reg == BUS && g_cyc) begin
      if (!g_stb) blocked_next = 1'b0;
      if (s_stb && !bus.i_s_ack) begin
        if (wd_cnt_reg == WD_LIMIT) begin
          err_next     = gnt_reg;
          blocked_next = 1'b1;
          if (timeout_cnt_reg != 8'hFF) timeout_cnt_next = timeout_cnt_reg + 8'd1;
        end else begin
          wd_cnt_next = wd_cnt_reg + 16'd1;
        end
      end
    end else begin
      blocked_next = 1'b0;
    end
  end

  assign bus.o_s_cyc       = s_cyc;
  assign bus.o_s_stb       = s_stb;
  assign bus.o_s_we        = s_we;
  assign bus.o_s_adr       = s_adr;
  assign bus.o_s_dat       = s_dat;
  assign bus.o_gnt         = gnt_reg;
  assign bus.o_m_ack       = {NUM_MASTERS{bus.i_s_ack}} & gnt_reg;
  assign bus.o_m_dat       = bus.i_s_dat;
  assign bus.o_m_err       = err_reg;
  assign bus.o_timeout_cnt = timeout_cnt_reg;
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: three masters, 4-cycle watchdog,
// hand-computed grant order, ack/err timing and asynchronous reset behaviour.
module tb_wb_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_master_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW)) bus ();

  wb_master_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr, input logic [7:0] dat);
    bus.i_m_cyc[i]          = cyc;
    bus.i_m_stb[i]          = stb;
    bus.i_m_we[i]           = we;
    bus.i_m_adr[i*AW +: AW] = adr;
    bus.i_m_dat[i*8 +: 8]   = dat;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n       = 1'b0;
    bus.i_m_cyc = '0;
    bus.i_m_stb = '0;
    bus.i_m_we  = '0;
    bus.i_m_adr = '0;
    bus.i_m_dat = '0;
    bus.i_s_dat = '0;
    bus.i_s_ack = 1'b0;
    #12;
    check("rst_gnt", 32'(bus.o_gnt), 32'h0);
    check("rst_s_cyc", 32'(bus.o_s_cyc), 32'h0);
    check("rst_err", 32'(bus.o_m_err), 32'h0);
    check("rst_tocnt", 32'(bus.o_timeout_cnt), 32'h0);
    tick();
    rst_n = 1'b1;

    // Contention: all three request together, grant order 0,1,2.
    set_m(0, 1, 1, 0, 16'h0100, 8'h00);
    set_m(1, 1, 1, 0, 16'h0101, 8'h00);
    set_m(2, 1, 1, 0, 16'h0102, 8'h00);
    tick();
    check("cont_gnt0", 32'(bus.o_gnt), 32'h1);
    check("cont_adr0", 32'(bus.o_s_adr), 32'h0100);
    check("cont_stb0", 32'(bus.o_s_stb), 32'h1);
    check("cont_we0", 32'(bus.o_s_we), 32'h0);
    bus.i_s_ack = 1'b1;
    #1;
    check("cont_ack0", 32'(bus.o_m_ack), 32'h1);
    tick();
    set_m(0, 0, 0, 0, 16'h0000, 8'h00);
    bus.i_s_ack = 1'b0;
    $display("[TB] txn contention read m0 done");
    tick();
    check("cont_idle1", 32'(bus.o_gnt), 32'h0);
    check("cont_idle1_cyc", 32'(bus.o_s_cyc), 32'h0);
    tick();
    check("cont_gnt1", 32'(bus.o_gnt), 32'h2);
    check("cont_adr1", 32'(bus.o_s_adr), 32'h0101);
    bus.i_s_ack = 1'b1;
    #1;
    check("cont_ack1", 32'(bus.o_m_ack), 32'h2);
    tick();
    set_m(1, 0, 0, 0, 16'h0000, 8'h00);
    bus.i_s_ack = 1'b0;
    $display("[TB] txn contention read m1 done");
    tick();
    check("cont_idle2", 32'(bus.o_gnt), 32'h0);
    tick();
    check("cont_gnt2", 32'(bus.o_gnt), 32'h4);
    check("cont_adr2", 32'(bus.o_s_adr), 32'h0102);
    bus.i_s_dat = 8'hC3;
    bus.i_s_ack = 1'b1;
    #1;
    check("rd_dat", 32'(bus.o_m_dat), 32'hC3);
    check("rd_ack", 32'(bus.o_m_ack), 32'h4);
    tick();
    set_m(2, 0, 0, 0, 16'h0000, 8'h00);
    set_m(0, 1, 1, 0, 16'h0110, 8'h00);
    bus.i_s_ack = 1'b0;
    $display("[TB] txn contention read m2 done");
    tick();
    set_m(2, 1, 1, 0, 16'h0112, 8'h00);
    tick();
    check("wrap_gnt0", 32'(bus.o_gnt), 32'h1);
    check("wrap_adr0", 32'(bus.o_s_adr), 32'h0110);
    set_m(0, 0, 0, 0, 16'h0000, 8'h00);
    tick();
    tick();
    check("wrap_gnt2", 32'(bus.o_gnt), 32'h4);
    set_m(2, 0, 0, 0, 16'h0000, 8'h00);
    tick();
    $display("[TB] txn wrap-around re-request done");

    // Single master write from master 1, slave acks two cycles after stb.
    set_m(1, 1, 1, 1, 16'h0012, 8'h5A);
    tick();
    check("wr_gnt", 32'(bus.o_gnt), 32'h2);
    check("wr_adr", 32'(bus.o_s_adr), 32'h0012);
    check("wr_dat", 32'(bus.o_s_dat), 32'h5A);
    check("wr_we", 32'(bus.o_s_we), 32'h1);
    check("wr_noack", 32'(bus.o_m_ack), 32'h0);
    tick();
    tick();
    bus.i_s_ack = 1'b1;
    #1;
    check("wr_ack", 32'(bus.o_m_ack), 32'h2);
    tick();
    bus.i_s_ack = 1'b0;
    set_m(1, 0, 0, 0, 16'h0000, 8'h00);
    tick();
    $display("[TB] txn single write m1 done");

    // Watchdog timeout on master 2: slave never acks.
    set_m(2, 1, 1, 0, 16'h0200, 8'h00);
    tick();
    check("to_gnt", 32'(bus.o_gnt), 32'h4);
    check("to_stb1", 32'(bus.o_s_stb), 32'h1);
    tick();
    tick();
    tick();
    check("to_noerr4", 32'(bus.o_m_err), 32'h0);
    check("to_stb4", 32'(bus.o_s_stb), 32'h1);
    tick();
    check("to_err5", 32'(bus.o_m_err), 32'h4);
    check("to_blk5", 32'(bus.o_s_stb), 32'h0);
    check("to_cnt5", 32'(bus.o_timeout_cnt), 32'h1);
    tick();
    check("to_err6", 32'(bus.o_m_err), 32'h0);
    check("to_blk6", 32'(bus.o_s_stb), 32'h0);
    set_m(2, 1, 0, 0, 16'h0200, 8'h00);
    tick();
    set_m(2, 1, 1, 0, 16'h0204, 8'h00);
    #1;
    check("to_restb", 32'(bus.o_s_stb), 32'h1);
    $display("[TB] txn timeout m2 done");

    // Ack on the 4th strobe cycle beats the watchdog.
    tick();
    tick();
    tick();
    bus.i_s_ack = 1'b1;
    #1;
    check("lim_ack", 32'(bus.o_m_ack), 32'h4);
    tick();
    bus.i_s_ack = 1'b0;
    set_m(2, 0, 0, 0, 16'h0000, 8'h00);
    check("lim_noerr", 32'(bus.o_m_err), 32'h0);
    check("lim_cnt", 32'(bus.o_timeout_cnt), 32'h1);
    tick();
    $display("[TB] txn ack-at-limit m2 done");

    // Ack while idle reaches nobody.
    bus.i_s_ack = 1'b1;
    #1;
    check("idle_ack", 32'(bus.o_m_ack), 32'h0);
    bus.i_s_ack = 1'b0;

    // Asynchronous reset while master 0 holds the bus.
    set_m(0, 1, 1, 1, 16'h0300, 8'h11);
    tick();
    check("rm_gnt0", 32'(bus.o_gnt), 32'h1);
    set_m(1, 1, 1, 0, 16'h0301, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_gnt", 32'(bus.o_gnt), 32'h0);
    check("rm_cyc", 32'(bus.o_s_cyc), 32'h0);
    check("rm_tocnt", 32'(bus.o_timeout_cnt), 32'h0);
    set_m(0, 0, 0, 0, 16'h0000, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_gnt1", 32'(bus.o_gnt), 32'h2);
    check("rm_adr1", 32'(bus.o_s_adr), 32'h0301);
    set_m(1, 0, 0, 0, 16'h0000, 8'h00);
    tick();
    $display("[TB] txn reset mid-transfer done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
